// File: rtl/cpu_controller_if.sv
// ============================================================================
// Module      : cpu_controller_if
// Description : Control bundle between the multicycle controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_controller_if #(
    parameter int SIZE = 16
);
    logic [SIZE-1:0] instr;
    logic [1:0]      flags1out;
    logic [2:0]      flags2out;
    logic            MemW1en;
    logic            MemW2en;
    logic            RFen;
    logic            PSRen;
    logic            PCen;
    logic            INSTRen;
    logic            Movm;
    logic            A1m;
    logic [1:0]      PCm;
    logic [1:0]      A2m;
    logic [1:0]      RWm;
    logic [3:0]      aluOp;
    logic [3:0]      state;

    modport master (
        input  instr, flags1out, flags2out,
        output MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen,
               Movm, A1m, PCm, A2m, RWm, aluOp, state
    );

    modport slave (
        output instr, flags1out, flags2out,
        input  MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen,
               Movm, A1m, PCm, A2m, RWm, aluOp, state
    );
endinterface

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module      : cpu_controller
// Description : Multicycle FSM for the CR16-subset datapath (Moore outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller #(
    parameter int SIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    cpu_controller_if.master   bus
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] EXEC   = 4'd2;
    localparam logic [3:0] LDRD   = 4'd3;
    localparam logic [3:0] LDWB   = 4'd4;
    localparam logic [3:0] STORE  = 4'd5;
    localparam logic [3:0] JUMP   = 4'd6;
    localparam logic [3:0] BRANCH = 4'd7;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_LUI = 4'b1111;
    localparam logic [3:0] EXT_JAL = 4'b1000;

    logic [3:0]      cur_state;
    logic [3:0]      next_state;
    logic [SIZE-1:0] instr_w;
    logic [15:0]     ir;
    logic            is_rtype;
    logic [3:0]      op_code;
    logic [1:0]      a2_sel;
    logic            cond_true;
    logic            flag_c, flag_l, flag_f, flag_z, flag_n;
    logic            unused_bits;

    assign instr_w     = bus.instr;
    assign ir          = instr_w[15:0];
    assign unused_bits = ^ir[3:0];

    // R-type carries its operation in the ext field; immediates reuse the opcode
    assign is_rtype = (ir[15:12] == 4'b0000);
    assign op_code  = is_rtype ? ir[7:4] : ir[15:12];
    assign a2_sel   = is_rtype ? 2'd0 : 2'd2;

    assign flag_c = bus.flags1out[1];
    assign flag_l = bus.flags1out[0];
    assign flag_f = bus.flags2out[2];
    assign flag_z = bus.flags2out[1];
    assign flag_n = bus.flags2out[0];

    always_comb begin
        cond_true = 1'b0;
        case (ir[11:8])
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_l;
            4'b0101: cond_true = ~flag_l;
            4'b0110: cond_true = flag_n;
            4'b0111: cond_true = ~flag_n;
            4'b1010: cond_true = flag_f;
            4'b1011: cond_true = ~flag_f;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (ir[15:12])
                    4'b0000, OP_ADD, OP_SUB, OP_CMP, OP_AND,
                    OP_OR, OP_XOR, OP_MOV, OP_LUI: next_state = EXEC;
                    4'b0100: begin
                        case (ir[7:4])
                            4'b0000:          next_state = LDRD;
                            4'b0100:          next_state = STORE;
                            4'b1000, 4'b1100: next_state = JUMP;
                            default:          next_state = FETCH;
                        endcase
                    end
                    4'b1100: next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            LDRD:    next_state = LDWB;
            default: next_state = FETCH;
        endcase
    end

    assign bus.state   = cur_state;
    assign bus.MemW1en = 1'b0;

    // Outputs are held at zero during reset so an abandoned op cannot commit
    always_comb begin
        bus.MemW2en = 1'b0;
        bus.RFen    = 1'b0;
        bus.PSRen   = 1'b0;
        bus.PCen    = 1'b0;
        bus.INSTRen = 1'b0;
        bus.Movm    = 1'b0;
        bus.A1m     = 1'b0;
        bus.PCm     = 2'd0;
        bus.A2m     = 2'd0;
        bus.RWm     = 2'd0;
        bus.aluOp   = ALU_ADD;
        if (!reset) begin
            case (cur_state)
                DECODE: begin
                    bus.INSTRen = 1'b1;
                    bus.PCen    = 1'b1;
                end
                EXEC: begin
                    case (op_code)
                        OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                            bus.A2m  = a2_sel;
                            bus.Movm = 1'b1;
                            bus.RWm  = 2'd2;
                            bus.RFen = (op_code != OP_CMP);
                            bus.PSRen = (op_code == OP_ADD) || (op_code == OP_SUB) ||
                                        (op_code == OP_CMP);
                            case (op_code)
                                OP_SUB, OP_CMP: bus.aluOp = ALU_SUB;
                                OP_AND:         bus.aluOp = ALU_AND;
                                OP_OR:          bus.aluOp = ALU_OR;
                                OP_XOR:         bus.aluOp = ALU_XOR;
                                default:        bus.aluOp = ALU_ADD;
                            endcase
                        end
                        OP_MOV: begin
                            bus.A2m  = a2_sel;
                            bus.RWm  = 2'd2;
                            bus.RFen = 1'b1;
                        end
                        OP_LUI: begin
                            if (!is_rtype) begin
                                bus.A2m  = 2'd2;
                                bus.RWm  = 2'd3;
                                bus.RFen = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                LDWB: begin
                    bus.RFen = 1'b1;
                end
                STORE: begin
                    bus.MemW2en = 1'b1;
                end
                JUMP: begin
                    // JAL links PC+1 while PC loads the register's old value
                    if (ir[7:4] == EXT_JAL) begin
                        bus.RFen = 1'b1;
                        bus.RWm  = 2'd1;
                        bus.PCen = 1'b1;
                        bus.PCm  = 2'd1;
                    end else if (cond_true) begin
                        bus.PCen = 1'b1;
                        bus.PCm  = 2'd1;
                    end
                end
                BRANCH: begin
                    bus.A1m  = 1'b1;
                    bus.A2m  = 2'd2;
                    bus.PCm  = 2'd2;
                    bus.PCen = cond_true;
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module      : tb_cpu_controller
// Description : Scoreboard bench for cpu_controller state/output sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_LDRD   = 4'd3;
    localparam logic [3:0] S_LDWB   = 4'd4;
    localparam logic [3:0] S_STORE  = 4'd5;
    localparam logic [3:0] S_JUMP   = 4'd6;
    localparam logic [3:0] S_BRANCH = 4'd7;
    localparam logic [21:0] ALL     = 22'h3FFFFF;
    localparam logic [21:0] NO_PCM  = 22'h3FFCFF;

    typedef struct {
        logic [21:0] word;
        logic [21:0] mask;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [21:0] obs_w;
    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;

    cpu_controller_if #(.SIZE(16)) bus ();

    cpu_controller #(.SIZE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_w = {bus.state, bus.MemW1en, bus.MemW2en, bus.RFen, bus.PSRen,
                    bus.PCen, bus.INSTRen, bus.Movm, bus.A1m, bus.PCm, bus.A2m,
                    bus.RWm, bus.aluOp};

    function automatic logic [21:0] cw(input logic [3:0] st, input logic mw2,
                                       input logic rf, input logic psr,
                                       input logic pc, input logic ir,
                                       input logic movm, input logic a1m,
                                       input logic [1:0] pcm, input logic [1:0] a2m,
                                       input logic [1:0] rwm, input logic [3:0] alu);
        return {st, 1'b0, mw2, rf, psr, pc, ir, movm, a1m, pcm, a2m, rwm, alu};
    endfunction

    task automatic check_val(input string tag, input logic [21:0] obs,
                             input logic [21:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, obs_w & e.mask, e.word & e.mask);
        end
    end

    task automatic push(input string tag, input logic [21:0] w,
                        input logic [21:0] m);
        exp_t e;
        e.word = w;
        e.mask = m;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic start(input logic [15:0] i, input logic [1:0] f1,
                         input logic [2:0] f2);
        bus.instr     = i;
        bus.flags1out = f1;
        bus.flags2out = f2;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag);
        push({tag, "_fetch"}, cw(S_FETCH, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        push({tag, "_decode"}, cw(S_DECODE, 0,0,0,1,1, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
    endtask

    // Three-cycle instruction: FETCH, DECODE, then one execute-type state
    task automatic run3(input string tag, input logic [15:0] i, input logic [1:0] f1,
                        input logic [2:0] f2, input logic [21:0] w,
                        input logic [21:0] m);
        start(i, f1, f2);
        fetch_decode(tag);
        push(tag, w, m);
        step(3);
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        start(16'h0000, 2'b00, 3'b000);
        step(3);
        push("reset", cw(S_FETCH, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        step(1);
        reset = 1'b0;

        run3("add",  16'h0152, 2'b00, 3'b000, cw(S_EXEC, 0,1,1,0,0, 1,0, 2'd0,2'd0,2'd2,4'd0), ALL);
        run3("cmpi", 16'hB305, 2'b00, 3'b000, cw(S_EXEC, 0,0,1,0,0, 1,0, 2'd0,2'd2,2'd2,4'd1), ALL);
        run3("subi", 16'h9207, 2'b00, 3'b000, cw(S_EXEC, 0,1,1,0,0, 1,0, 2'd0,2'd2,2'd2,4'd1), ALL);
        run3("andi", 16'h1203, 2'b00, 3'b000, cw(S_EXEC, 0,1,0,0,0, 1,0, 2'd0,2'd2,2'd2,4'd2), ALL);
        run3("or",   16'h0122, 2'b00, 3'b000, cw(S_EXEC, 0,1,0,0,0, 1,0, 2'd0,2'd0,2'd2,4'd3), ALL);
        run3("xor",  16'h0132, 2'b00, 3'b000, cw(S_EXEC, 0,1,0,0,0, 1,0, 2'd0,2'd0,2'd2,4'd4), ALL);
        run3("movi", 16'hD20A, 2'b00, 3'b000, cw(S_EXEC, 0,1,0,0,0, 0,0, 2'd0,2'd2,2'd2,4'd0), ALL);
        run3("lui",  16'hF212, 2'b00, 3'b000, cw(S_EXEC, 0,1,0,0,0, 0,0, 2'd0,2'd2,2'd3,4'd0), ALL);
        run3("badext", 16'h0172, 2'b00, 3'b000, cw(S_EXEC, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);

        start(16'h6000, 2'b00, 3'b000);
        fetch_decode("nop");
        step(2);

        start(16'h4203, 2'b00, 3'b000);
        fetch_decode("load");
        push("load_rd", cw(S_LDRD, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        push("load_wb", cw(S_LDWB, 0,1,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        step(4);

        run3("store", 16'h4243, 2'b00, 3'b000, cw(S_STORE, 1,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);

        run3("beq_t",  16'hC0FE, 2'b00, 3'b010, cw(S_BRANCH, 0,0,0,1,0, 0,1, 2'd2,2'd2,2'd0,4'd0), ALL);
        run3("beq_nt", 16'hC0FE, 2'b00, 3'b000, cw(S_BRANCH, 0,0,0,0,0, 0,1, 2'd0,2'd2,2'd0,4'd0), NO_PCM);
        run3("bcs_t",  16'hC210, 2'b10, 3'b000, cw(S_BRANCH, 0,0,0,1,0, 0,1, 2'd2,2'd2,2'd0,4'd0), ALL);
        run3("bhi_nt", 16'hC410, 2'b10, 3'b111, cw(S_BRANCH, 0,0,0,0,0, 0,1, 2'd0,2'd2,2'd0,4'd0), NO_PCM);
        run3("ble_t",  16'hC710, 2'b00, 3'b110, cw(S_BRANCH, 0,0,0,1,0, 0,1, 2'd2,2'd2,2'd0,4'd0), ALL);
        run3("buc_t",  16'hCE10, 2'b00, 3'b000, cw(S_BRANCH, 0,0,0,1,0, 0,1, 2'd2,2'd2,2'd0,4'd0), ALL);
        run3("bnv_nt", 16'hC810, 2'b11, 3'b111, cw(S_BRANCH, 0,0,0,0,0, 0,1, 2'd0,2'd2,2'd0,4'd0), NO_PCM);

        run3("jal",    16'h4E85, 2'b00, 3'b000, cw(S_JUMP, 0,1,0,1,0, 0,0, 2'd1,2'd0,2'd1,4'd0), ALL);
        run3("jne_nt", 16'h41C5, 2'b00, 3'b010, cw(S_JUMP, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        run3("jfs_t",  16'h4AC5, 2'b00, 3'b100, cw(S_JUMP, 0,0,0,1,0, 0,0, 2'd1,2'd0,2'd0,4'd0), ALL);

        // Reset asserted while the load is in its write-back cycle
        start(16'h4203, 2'b00, 3'b000);
        fetch_decode("rst_load");
        push("rst_load_rd", cw(S_LDRD, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        step(3);
        reset = 1'b1;
        push("rst_in_ldwb", cw(S_LDWB, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        step(1);
        push("rst_next", cw(S_FETCH, 0,0,0,0,0, 0,0, 2'd0,2'd0,2'd0,4'd0), ALL);
        step(1);
        reset = 1'b0;

        run3("add_after_rst", 16'h0152, 2'b00, 3'b000, cw(S_EXEC, 0,1,1,0,0, 1,0, 2'd0,2'd0,2'd2,4'd0), ALL);

        budget = 0;
        while (sbq.size() > 0 && budget < 20) begin
            step(1);
            budget++;
        end
        if (sbq.size() > 0) check_val("drain", 22'(sbq.size()), 22'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multicycle control FSM that sequences the 16-bit CR16-subset datapath: fetch, decode, execute, memory access, write-back.
- Consumes the latched instruction and the PSR flags.
- Drives every datapath enable, every mux select, and aluOp.
- Replaces the temporary test FSM. Outputs are Moore-style: combinational decode of the state register, plus instr fields in the execute-type states.

Parameters:
SIZE, 16, instruction/data width; only instr[15:0] is decoded.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
instr  input  SIZE  instruction register contents
flags1out  input  2  PSR {C,L}: [1]=C, [0]=L
flags2out  input  3  PSR {F,Z,N}: [2]=F, [1]=Z, [0]=N
MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen  output  1 each  datapath enables
Movm, A1m  output  1 each  mux selects (Movm 0=A2MuxOut, 1=aluOut; A1m 0=RFread1, 1=PC)
PCm  output  2  0=nextPC, 1=RFread2, 2=aluOut
A2m  output  2  0=RFread2, 1=instr[3:0], 2=seImmd
RWm  output  2  0=MemRead2, 1=nextPC, 2=MovMuxOut, 3=luiImmd
aluOp  output  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4
state  output  4  current state, for debug/LEDs

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. While reset=1 the next state is FETCH.
- Default outputs: every output is 0 unless listed below for the current state. MemW1en is never asserted (instruction memory is read-only).
- FETCH:
  - Outputs: defaults only; the BRAM port A read of PC is in flight.
  - Next state: DECODE.
- DECODE:
  - Outputs: INSTRen=1, PCen=1, PCm=0. The instruction is latched and PC+1 is taken on the same edge.
  - Next state by instr[15:12]:
    - 0000, 0101, 1001, 1011, 0001, 0010, 0011, 1101, 1111 → EXEC.
    - 0100: ext instr[7:4]=0000 → LDRD; 0100 → STORE; 1000 or 1100 → JUMP.
    - 1100 → BRANCH.
    - Anything else → FETCH (executes as a NOP).
- EXEC:
  - R-type (op 0000): ext instr[7:4] picks the operation. 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV. A2m=0.
  - Immediate: same op codes in instr[15:12], with A2m=2. 1111 is LUI.
  - ALU ops: A1m=0, Movm=1, RWm=2, RFen=1. CMP and CMPI use aluOp=SUB with RFen=0.
  - MOV/MOVI: Movm=0, RWm=2, RFen=1.
  - LUI: RWm=3, RFen=1.
  - PSRen=1 only for ADD, SUB, CMP and their immediate forms.
  - Unrecognised ext: all outputs 0.
  - Next state: FETCH.
- LDRD: defaults only (port B read latency). Next state: LDWB.
- LDWB: RFen=1, RWm=0. Next state: FETCH.
- STORE: MemW2en=1 for exactly one cycle. Next state: FETCH.
- JUMP:
  - Condition field is instr[11:8].
  - If taken: PCen=1, PCm=1.
  - JAL (ext 1000): always taken; also RFen=1, RWm=1. PC takes the pre-write register value.
  - Next state: FETCH.
- BRANCH:
  - Outputs: A1m=1, A2m=2, aluOp=ADD (PC+1 + sign-extended displacement).
  - PCen=1 only if the condition is true.
  - Next state: FETCH.
- Conditions (instr[11:8]):
  - 0000 EQ Z=1; 0001 NE Z=0.
  - 0010 CS C=1; 0011 CC C=0.
  - 0100 HI L=1; 0101 LS L=0.
  - 0110 GT N=1; 0111 LE N=0.
  - 1010 FS F=1; 1011 FC F=0.
  - 1110 UC always taken.
  - All other codes: never taken.
- Latency: ALU, store, jump and branch instructions take 3 cycles; loads take 4.
- Flags are sampled in the JUMP/BRANCH cycle. A PSR write from the previous instruction is already visible there.
- Reset mid-instruction: the in-flight operation is abandoned. No enable is asserted in the reset cycle; the cycle after reset deasserts is FETCH.

Test Plan:
1. Assert reset during LDWB → state=FETCH next cycle; RFen, PCen, MemW2en all 0.
2. ADD, instr=0x0152 → FETCH, DECODE (INSTRen=1, PCen=1, PCm=0), EXEC (aluOp=0, A2m=0, Movm=1, RWm=2, RFen=1, PSRen=1), then FETCH.
3. CMPI, instr=0xB305 → EXEC: aluOp=1, A2m=2, PSRen=1, RFen=0.
4. BEQ, instr=0xC0FE, flags2out=3'b010 → BRANCH: PCen=1, PCm=2, A1m=1, A2m=2, aluOp=0. Repeat with Z=0 → PCen=0.
5. LOAD, instr=0x4203 → states FETCH, DECODE, LDRD, LDWB (RFen=1, RWm=0); returns to FETCH after 4 cycles. STORE, instr=0x4243 → MemW2en high for exactly 1 cycle.
6. JAL, instr=0x4E85 → JUMP: RFen=1, RWm=1, PCen=1, PCm=1. Jcond 0x41C5 (NE) with Z=1 → PCen=0.
